// File: rtl/chip_emulator_if.sv
// chip_emulator_if: checker-side configuration and DIP pin bus for the chip emulator
interface chip_emulator_if #(
  parameter int DLY_W = 3,
  parameter int CNT_W = 16
);
  logic             cfg_load;
  logic [2:0]       cfg_chip;
  logic [DLY_W-1:0] cfg_delay;
  logic             cfg_fault_en;
  logic [2:0]       cfg_fault_gate;
  logic             cfg_fault_val;
  logic [13:0]      pin_in;
  logic [13:0]      pin_out;
  logic [13:0]      pin_oe;
  logic             ready;
  logic             cfg_err;
  logic [CNT_W-1:0] vec_count;
  modport master (
    output cfg_load, cfg_chip, cfg_delay, cfg_fault_en, cfg_fault_gate, cfg_fault_val, pin_in,
    input  pin_out, pin_oe, ready, cfg_err, vec_count
  );
  modport slave (
    input  cfg_load, cfg_chip, cfg_delay, cfg_fault_en, cfg_fault_gate, cfg_fault_val, pin_in,
    output pin_out, pin_oe, ready, cfg_err, vec_count
  );
endinterface

// File: rtl/chip_emulator.sv
// chip_emulator: emulates a 74xx quad/hex gate chip on a 14-pin DIP with delay, stuck-at faults and vector counting
module chip_emulator #(
  parameter int DLY_W = 3,
  parameter int CNT_W = 16
) (
  input logic      clk,
  input logic      rst_n,
  chip_emulator_if.slave bus
);
  localparam int NSTG = (1 << DLY_W) - 1;
  typedef enum logic [1:0] {IDLE, FILL, ACTIVE, ERROR} state_t;
  state_t           r_state, w_nxt;
  logic [2:0]       r_chip, r_fg;
  logic             r_fen, r_fv, r_err, r_base;
  logic [DLY_W-1:0] r_dly;
  logic [DLY_W+1:0] r_fill;
  logic [13:0]      r_sync1, r_sync2, r_prev, r_out;
  logic [13:0]      r_dl [NSTG];
  logic [CNT_W-1:0] r_cnt;
  logic             w_nor, w_inv, w_act;
  logic [5:0]       w_x, w_ye, w_g, w_fm, w_f;
  logic [13:0]      w_res, w_omask, w_imask, w_cur;
  assign w_nor = r_chip == 3'd1;
  assign w_inv = r_chip == 3'd2;
  assign w_act = r_state == ACTIVE;
  // first gate operand per gate, ordered by ascending output pin
  assign w_x = w_nor ? {2'b0, r_sync2[11], r_sync2[8], r_sync2[5], r_sync2[2]}
             : w_inv ? {r_sync2[13], r_sync2[11], r_sync2[9], r_sync2[5], r_sync2[3], r_sync2[1]}
             : {2'b0, r_sync2[12], r_sync2[9], r_sync2[4], r_sync2[1]};
  assign w_ye = w_nor ? {2'b0, r_sync2[12], r_sync2[9], r_sync2[6], r_sync2[3]}
              : {2'b0, r_sync2[13], r_sync2[10], r_sync2[5], r_sync2[2]};
  assign w_g = r_chip == 3'd0 ? ~(w_x & w_ye)
             : r_chip == 3'd1 ? ~(w_x | w_ye)
             : r_chip == 3'd2 ? ~w_x
             : r_chip == 3'd3 ? w_x & w_ye
             : r_chip == 3'd4 ? w_x | w_ye
             : w_x ^ w_ye;
  // gate indices past the chip's gate count shift out of the mask and so have no effect
  assign w_fm = (6'd1 << r_fg) & (w_inv ? 6'h3f : 6'h0f) & {6{r_fen}};
  assign w_f  = (w_g & ~w_fm) | ({6{r_fv}} & w_fm);
  assign w_omask = w_nor ? 14'h2412 : w_inv ? 14'h1554 : 14'h0948;
  assign w_imask = w_nor ? 14'h1b6c : w_inv ? 14'h2a2a : 14'h3636;
  assign w_cur   = r_sync2 & w_imask;
  assign bus.pin_out   = w_act ? r_out & w_omask : '0;
  assign bus.pin_oe    = w_act ? w_omask : '0;
  assign bus.ready     = w_act;
  assign bus.cfg_err   = r_err;
  assign bus.vec_count = r_cnt;
  // scatter gate results onto their output pins
  always_comb begin
    w_res = '0;
    if (w_nor) {w_res[13], w_res[10], w_res[4], w_res[1]} = w_f[3:0];
    else if (w_inv) {w_res[12], w_res[10], w_res[8], w_res[6], w_res[4], w_res[2]} = w_f;
    else {w_res[11], w_res[8], w_res[6], w_res[3]} = w_f[3:0];
  end
  // next state: a load always wins over FILL completion
  always_comb begin
    w_nxt = r_state;
    if (bus.cfg_load) w_nxt = bus.cfg_chip > 3'd5 ? ERROR : FILL;
    else if (r_state == FILL && r_fill == (DLY_W+2)'(1)) w_nxt = ACTIVE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  // configuration latch and fill counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chip <= '0;
      r_dly  <= '0;
      r_fen  <= 1'b0;
      r_fg   <= '0;
      r_fv   <= 1'b0;
      r_err  <= 1'b0;
      r_fill <= '0;
    end else if (bus.cfg_load) begin
      r_chip <= bus.cfg_chip;
      r_dly  <= bus.cfg_delay;
      r_fen  <= bus.cfg_fault_en;
      r_fg   <= bus.cfg_fault_gate;
      r_fv   <= bus.cfg_fault_val;
      r_err  <= bus.cfg_chip > 3'd5;
      r_fill <= (DLY_W+2)'(bus.cfg_delay) + (DLY_W+2)'(3);
    end else if (r_state == FILL) r_fill <= r_fill - (DLY_W+2)'(1);
  end
  // synchronizer, delay line, output register and vector counter, all flushed by a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.cfg_load) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
      r_base  <= 1'b0;
      for (int i = 0; i < NSTG; i++) r_dl[i] <= '0;
    end else begin
      r_sync1 <= bus.pin_in;
      r_sync2 <= r_sync1;
      r_prev  <= w_cur;
      r_dl[0] <= w_res;
      for (int i = 1; i < NSTG; i++) r_dl[i] <= r_dl[i-1];
      r_out <= r_dly == '0 ? w_res : r_dl[r_dly - DLY_W'(1)];
      if (w_act) begin
        r_base <= 1'b1;
        if (r_base && w_cur != r_prev && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_chip_emulator.sv
// tb_chip_emulator: randomized scoreboard bench for chip_emulator against a pin-table reference model
module tb_chip_emulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  chip_emulator_if #(.DLY_W(3), .CNT_W(16)) bus();
  chip_emulator #(.DLY_W(3), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  localparam int QA[4] = '{1, 4, 9, 12};
  localparam int QB[4] = '{2, 5, 10, 13};
  localparam int QO[4] = '{3, 6, 8, 11};
  localparam int NA[4] = '{2, 5, 8, 11};
  localparam int NB[4] = '{3, 6, 9, 12};
  localparam int NO[4] = '{1, 4, 10, 13};
  localparam int IA[6] = '{1, 3, 5, 9, 11, 13};
  localparam int IO[6] = '{2, 4, 6, 8, 10, 12};
  typedef struct {
    int          due;
    logic [13:0] po;
    logic [13:0] oe;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int m_chip, m_dly, m_fg, m_vc;
  bit m_fen, m_fv;
  logic [13:0] m_prev;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int ngates(int c);
    return c == 2 ? 6 : 4;
  endfunction
  function automatic int pa(int c, int g);
    return c == 1 ? NA[g] : c == 2 ? IA[g] : QA[g];
  endfunction
  function automatic int pb(int c, int g);
    return c == 1 ? NB[g] : QB[g];
  endfunction
  function automatic int po(int c, int g);
    return c == 1 ? NO[g] : c == 2 ? IO[g] : QO[g];
  endfunction
  function automatic logic [13:0] ref_out(int c, logic [13:0] p);
    logic [13:0] r = '0;
    for (int g = 0; g < ngates(c); g++) begin
      logic x, y, v;
      x = p[pa(c, g)];
      y = c == 2 ? 1'b0 : p[pb(c, g)];
      case (c)
        0: v = !(x && y);
        1: v = !(x || y);
        2: v = !x;
        3: v = x && y;
        4: v = x || y;
        default: v = x != y;
      endcase
      if (m_fen && m_fg == g) v = m_fv;
      r[po(c, g)] = v;
    end
    return r;
  endfunction
  function automatic logic [13:0] ref_omask(int c);
    logic [13:0] r = '0;
    for (int g = 0; g < ngates(c); g++) r[po(c, g)] = 1'b1;
    return r;
  endfunction
  function automatic logic [13:0] ref_imask(int c);
    logic [13:0] r = '0;
    for (int g = 0; g < ngates(c); g++) begin
      r[pa(c, g)] = 1'b1;
      if (c != 2) r[pb(c, g)] = 1'b1;
    end
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask
  // monitor: pops expectations as their due cycle arrives
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("pin_out", 32'(bus.pin_out), 32'(e.po));
      chk("pin_oe", 32'(bus.pin_oe), 32'(e.oe));
    end
  end
  task automatic drive(logic [13:0] p);
    exp_t e;
    logic [13:0] im;
    @(negedge clk);
    #1;
    bus.pin_in = p;
    e.due = cyc + 3 + m_dly;
    e.po  = ref_out(m_chip, p);
    e.oe  = ref_omask(m_chip);
    q.push_back(e);
    im = ref_imask(m_chip);
    if ((p & im) != (m_prev & im) && m_vc < 65535) m_vc++;
    m_prev = p;
  endtask
  task automatic load(int c, int d, bit fen, int fg, bit fv);
    @(negedge clk);
    #1;
    q.delete();
    bus.cfg_chip = 3'(c);
    bus.cfg_delay = 3'(d);
    bus.cfg_fault_en = fen;
    bus.cfg_fault_gate = 3'(fg);
    bus.cfg_fault_val = fv;
    bus.cfg_load = 1'b1;
    m_chip = c; m_dly = d; m_fen = fen; m_fg = fg; m_fv = fv;
    m_vc = 0;
    m_prev = bus.pin_in;
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
    chk("ready_after_load", 32'(bus.ready), 0);
  endtask
  task automatic wait_ready(int exp_n);
    int n = 0;
    while (!bus.ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("fill_len", n, exp_n);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask
  task automatic check_vec();
    repeat (4) @(posedge clk);
    #1;
    chk("vec_count", 32'(bus.vec_count), m_vc);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int seq[11] = '{1, 3, 2, 0, 1, 2, 3, 3, 1, 0, 2};
    bus.cfg_load = 0; bus.cfg_chip = 0; bus.cfg_delay = 0; bus.cfg_fault_en = 0;
    bus.cfg_fault_gate = 0; bus.cfg_fault_val = 0; bus.pin_in = '0;
    m_chip = 0; m_dly = 0; m_fen = 0; m_fg = 0; m_fv = 0; m_vc = 0; m_prev = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pin_out", 32'(bus.pin_out), 0);
    chk("rst_pin_oe", 32'(bus.pin_oe), 0);
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 0);
    chk("rst_vec_count", 32'(bus.vec_count), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ready", 32'(bus.ready), 0);
    load(0, 0, 0, 0, 0);
    wait_ready(3);
    chk("oe_7400", 32'(bus.pin_oe), 32'h0948);
    drive(14'h0006); drive(14'h0006); drive(14'h0002); drive(14'h0002); drive(14'h0004);
    drain();
    load(1, 5, 0, 0, 0);
    wait_ready(8);
    chk("oe_7402", 32'(bus.pin_oe), 32'h2412);
    drive(14'h000c); drive(14'h0000); drive(14'h0000); drive(14'h0008);
    drain();
    load(2, 0, 1, 5, 0);
    wait_ready(3);
    drive(14'h2002); drive(14'h0000); drive(14'h3ffe); drive(14'h0002);
    drain();
    load(6, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_cfg_err", 32'(bus.cfg_err), 1);
    chk("err_ready", 32'(bus.ready), 0);
    chk("err_pin_oe", 32'(bus.pin_oe), 0);
    load(3, 0, 0, 0, 0);
    wait_ready(3);
    chk("ok_cfg_err", 32'(bus.cfg_err), 0);
    load(0, 2, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("fill_ready_low", 32'(bus.ready), 0);
    load(4, 1, 0, 0, 0);
    wait_ready(4);
    for (int r = 0; r < 14; r++) begin
      int c, d;
      logic [13:0] p;
      c = $urandom_range(0, 5);
      d = $urandom_range(0, 7);
      load(c, d, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      wait_ready(d + 3);
      p = bus.pin_in;
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 3) != 0) p = 14'($urandom);
        drive(p);
      end
      drain();
      check_vec();
    end
    bus.pin_in = '0;
    load(4, 0, 0, 0, 0);
    wait_ready(3);
    for (int k = 0; k < 11; k++) drive(14'(seq[k] << 1));
    drain();
    check_vec();
    chk("vec_ten", m_vc, 10);
    for (int k = 0; k < 65540; k++) drive(14'((k & 1) << 1));
    drain();
    check_vec();
    chk("vec_sat", 32'(bus.vec_count), 32'hffff);
    drive(14'h0006); drive(14'h0000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_pin_oe", 32'(bus.pin_oe), 0);
    chk("arst_ready", 32'(bus.ready), 0);
    chk("arst_vec_count", 32'(bus.vec_count), 0);
    chk("arst_pin_out", 32'(bus.pin_out), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(bus.ready), 0);
    chk("post_rst_pin_oe", 32'(bus.pin_oe), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
